io_seq_monitor: RTL and testbench
=================================

IO_SEQ_MONITOR -- requirements
Module: io_seq_monitor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the width of the monitored IO bus.
REQ-002 The module SHALL have parameter DEPTH, default 16, giving the number of expected-value table entries.
REQ-003 The module SHALL have parameter TMO_W, default 16, giving the width of the timeout counter and limit.
REQ-004 wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-006 io_in  input  WIDTH  monitored IO pins (e.g. mprj_io[WIDTH-1:0]).
REQ-007 cfg_we  input  1  write strobe for expected-value table.
REQ-008 cfg_addr  input  clog2(DEPTH)  table write address.
REQ-009 cfg_data  input  WIDTH  table write data.
REQ-010 cfg_len  input  clog2(DEPTH+1)  sequence length; values above DEPTH are treated as DEPTH.
REQ-011 cfg_mask  input  WIDTH  compare mask; 1 = bit compared.
REQ-012 tmo_limit  input  TMO_W  idle-cycle limit per step; 0 disables timeout.
REQ-013 start  input  1  single-cycle pulse starting a run.
REQ-014 busy  output  1  high in WAIT state.
REQ-015 pass  output  1  sticky; full sequence matched.
REQ-016 timeout  output  1  sticky; limit reached before next match.
REQ-017 idx  output  clog2(DEPTH+1)  number of entries matched so far.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT, PASS, TMO; busy=1 only in WAIT, pass=1 only in PASS, timeout=1 only in TMO.
REQ-019 start in IDLE, PASS or TMO SHALL clear idx and the timeout counter and enter WAIT next edge; start in WAIT SHALL be ignored.
REQ-020 start with effective length 0 SHALL go directly to PASS on the next edge, with idx=0.
REQ-021 In WAIT a match SHALL be (io_s & cfg_mask) == (table[idx] & cfg_mask), evaluated combinationally on the sampled input io_s.
REQ-022 A match in cycle k SHALL increment idx and clear the timeout counter at the edge ending cycle k; the next entry is compared from cycle k+1.
REQ-023 A match on entry len-1 SHALL enter PASS at that same edge, with idx=len.
REQ-024 Each WAIT cycle without a match SHALL increment the timeout counter; when the counter equals tmo_limit (nonzero), the FSM SHALL enter TMO with idx frozen.
REQ-025 When a match and the limit being reached coincide, the match SHALL win.
REQ-026 The timeout counter SHALL saturate and never wrap.
REQ-027 cfg_we SHALL write table[cfg_addr] in IDLE, PASS or TMO; writes in WAIT SHALL be ignored.
REQ-028 cfg_len, cfg_mask and tmo_limit SHALL be sampled continuously; software holds them stable during WAIT.
REQ-029 The same value appearing for consecutive entries SHALL require only one cycle per entry; no intermediate change is needed.

Reset
REQ-030 wb_rst_i SHALL force IDLE, busy=0, pass=0, timeout=0, idx=0, timeout counter=0, and clear the synchroniser flops.
REQ-031 Reset SHALL NOT clear table contents; reset mid-run SHALL abort to IDLE, after which a start reruns from entry 0.

Configuration
REQ-032 With IO_SEQ_SYNC_EN defined, io_s SHALL be io_in passed through two wb_clk_i flops, adding 2 cycles of latency from pin to compare.
REQ-033 Without IO_SEQ_SYNC_EN, io_s SHALL equal io_in directly, with zero latency.

Verification
REQ-034 Load 01,02,...,0A,FF,00 (len 12), mask FF, limit 100, start, drive each value for 5 cycles -> pass=1, idx=12, timeout=0.
REQ-035 Same table, drive 01..04, then hold 04 -> timeout=1 exactly 100 cycles after the 04 match, idx=4, busy=0.
REQ-036 cfg_len=0, start -> pass=1 on the next cycle, idx=0.
REQ-037 table[0]=13, mask 0F, len 1, io_in=23 -> pass=1.
REQ-038 Reset at idx=5 mid-run -> IDLE, idx=0; start again without reload and replay the full sequence -> pass=1.
REQ-039 Start pulse while busy, then cfg_we to entry 3 while busy -> idx not cleared, table[3] unchanged; run completes with pass=1.

Source files
------------

// File: rtl/io_seq_monitor.sv
// io_seq_monitor: watches an IO bus step through a programmed table of masked values,
// flagging pass on a full match or timeout on a stalled step. Define IO_SEQ_SYNC_EN to synchronise io_in.
module io_seq_monitor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TMO_W = 16,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LW = $clog2(DEPTH + 1)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] io_in,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [LW-1:0]    cfg_len,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [TMO_W-1:0] tmo_limit,
  input  logic             start,
  output logic             busy,
  output logic             pass,
  output logic             timeout,
  output logic [LW-1:0]    idx
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_TMO  = 2'd3;

  logic [1:0]       r_state;
  logic [LW-1:0]    r_idx;
  logic [TMO_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_table [DEPTH];

  logic [1:0]       w_state_nxt;
  logic [LW-1:0]    w_idx_nxt;
  logic [TMO_W-1:0] w_cnt_nxt;
  logic [TMO_W-1:0] w_cnt_inc;
  logic [LW-1:0]    w_len;
  logic [WIDTH-1:0] w_io_s;
  logic [WIDTH-1:0] w_entry;
  logic [AW-1:0]    w_rd_addr;
  logic             w_match;
  logic             w_tbl_wr;

`ifdef IO_SEQ_SYNC_EN
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= io_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_io_s = r_sync2;
`else
  assign w_io_s = io_in;
`endif

  // Lengths beyond the table size are clipped to the table size.
  assign w_len = (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;

  // Table is not reset so a reset mid-run can be followed by a replay without reloading.
  assign w_tbl_wr = cfg_we && (r_state != S_WAIT) && (int'(cfg_addr) < int'(DEPTH));

  always_ff @(posedge wb_clk_i) begin
    if (w_tbl_wr) begin
      r_table[cfg_addr] <= cfg_data;
    end
  end

  // idx is always below the table size while in WAIT, so truncation is safe there.
  assign w_rd_addr = r_idx[AW-1:0];
  assign w_entry   = r_table[w_rd_addr];
  assign w_match   = ((w_io_s ^ w_entry) & cfg_mask) == '0;
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + TMO_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_WAIT: begin
        // A match takes priority over the limit being reached in the same cycle.
        if (w_match) begin
          w_idx_nxt = r_idx + LW'(1);
          w_cnt_nxt = '0;
          if (w_idx_nxt == w_len) begin
            w_state_nxt = S_PASS;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if ((tmo_limit != '0) && (w_cnt_inc == tmo_limit)) begin
            w_state_nxt = S_TMO;
          end
        end
      end
      default: begin
        if (start) begin
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = (w_len == '0) ? S_PASS : S_WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign busy    = (r_state == S_WAIT);
  assign pass    = (r_state == S_PASS);
  assign timeout = (r_state == S_TMO);
  assign idx     = r_idx;

endmodule

// File: tb/tb_io_seq_monitor.sv
// Self-checking bench for io_seq_monitor: directed scenarios then randomized traffic,
// all checked every cycle against a sequence-level reference model.
module tb_io_seq_monitor;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int TMO_W = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] io_in;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic [LW-1:0]    cfg_len;
  logic [WIDTH-1:0] cfg_mask;
  logic [TMO_W-1:0] tmo_limit;
  logic             start;
  logic             busy;
  logic             pass;
  logic             timeout;
  logic [LW-1:0]    idx;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: progress through the expected sequence plus an idle-cycle count.
  int m_tab [DEPTH];
  bit m_run, m_pass, m_tmo;
  int m_idx, m_cnt;
  int m_s1, m_s2;

  io_seq_monitor #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .TMO_W(TMO_W)
  ) u_dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .io_in    (io_in),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_len  (cfg_len),
    .cfg_mask (cfg_mask),
    .tmo_limit(tmo_limit),
    .start    (start),
    .busy     (busy),
    .pass     (pass),
    .timeout  (timeout),
    .idx      (idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_edge();
    int len, io_s;
    len = (int'(cfg_len) > DEPTH) ? DEPTH : int'(cfg_len);
`ifdef IO_SEQ_SYNC_EN
    io_s = m_s2;
`else
    io_s = int'(io_in);
`endif
    if (rst) begin
      m_run = 0; m_pass = 0; m_tmo = 0; m_idx = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0;
      return;
    end
    if (!m_run) begin
      if (cfg_we) m_tab[int'(cfg_addr)] = int'(cfg_data);
      if (start) begin
        m_idx = 0; m_cnt = 0; m_tmo = 0;
        m_pass = (len == 0);
        m_run  = (len != 0);
      end
    end else if (((io_s ^ m_tab[m_idx]) & int'(cfg_mask)) == 0) begin
      m_idx++;
      m_cnt = 0;
      if (m_idx == len) begin m_run = 0; m_pass = 1; end
    end else begin
      if (m_cnt < (1 << TMO_W) - 1) m_cnt++;
      if (int'(tmo_limit) != 0 && m_cnt == int'(tmo_limit)) begin m_run = 0; m_tmo = 1; end
    end
    m_s2 = m_s1;
    m_s1 = int'(io_in);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".flags"}, 32'({busy, pass, timeout}), 32'({m_run, m_pass, m_tmo}));
    check({tag, ".idx"}, 32'(idx), 32'(m_idx));
  endtask

  task automatic write_entry(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = WIDTH'(d);
    step("wr");
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    step(tag);
    start = 1'b0;
  endtask

  task automatic drive(input int v, input int n, input string tag);
    io_in = WIDTH'(v);
    repeat (n) step(tag);
  endtask

  int seq [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
                   8'hFF, 8'h00};
  int tmo_at;

  initial begin
    rst = 1'b1; io_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_len = '0; cfg_mask = '0; tmo_limit = '0; start = 1'b0;
    m_s1 = 0; m_s2 = 0;
    for (int i = 0; i < DEPTH; i++) m_tab[i] = 0;
    step("reset");
    step("reset");
    check("reset.busy", 32'(busy), 32'(0));
    rst = 1'b0;

    // Full 12-entry sequence, each value held 5 cycles.
    for (int i = 0; i < DEPTH; i++) write_entry(i, (i < 12) ? seq[i] : 8'hA0 + i);
    cfg_len = LW'(12); cfg_mask = 8'hFF; tmo_limit = 16'd100;
    pulse_start("run1.start");
    for (int i = 0; i < 12; i++) drive(seq[i], 5, "run1");
    check("run1.pass", 32'(pass), 32'(1));
    check("run1.idx", 32'(idx), 32'(12));
    check("run1.timeout", 32'(timeout), 32'(0));

    // Stall after 04: timeout 100 cycles after that match.
    pulse_start("run2.start");
    for (int i = 0; i < 4; i++) drive(seq[i], 1, "run2");
    tmo_at = -1;
    for (int n = 1; n <= 200; n++) begin
      step("run2.hold");
      if (timeout) begin tmo_at = n; break; end
    end
    check("run2.tmo_latency", 32'(tmo_at), 32'(100));
    check("run2.idx", 32'(idx), 32'(4));
    check("run2.busy", 32'(busy), 32'(0));

    // Zero length passes immediately.
    cfg_len = '0;
    pulse_start("len0.start");
    check("len0.pass", 32'(pass), 32'(1));
    check("len0.idx", 32'(idx), 32'(0));

    // Masked compare: only low nibble matters.
    write_entry(0, 8'h13);
    cfg_len = LW'(1); cfg_mask = 8'h0F; io_in = 8'h23;
    pulse_start("mask.start");
    step("mask");
    check("mask.pass", 32'(pass), 32'(1));

    // Reset mid-run, replay without reloading.
    write_entry(0, 8'h01);
    cfg_len = LW'(12); cfg_mask = 8'hFF;
    pulse_start("rst.start");
    for (int i = 0; i < 5; i++) drive(seq[i], 1, "rst.pre");
    check("rst.idx5", 32'(idx), 32'(5));
    rst = 1'b1;
    step("rst.assert");
    rst = 1'b0;
    check("rst.idx0", 32'(idx), 32'(0));
    check("rst.busy", 32'(busy), 32'(0));
    pulse_start("rst.restart");
    for (int i = 0; i < 12; i++) drive(seq[i], 1, "rst.replay");
    check("rst.pass", 32'(pass), 32'(1));

    // Start and table write while busy are ignored.
    pulse_start("busy.start");
    drive(seq[0], 1, "busy");
    drive(seq[1], 1, "busy");
    pulse_start("busy.restart");
    check("busy.idx_kept", 32'(idx), 32'(2));
    write_entry(3, 8'h77);
    for (int i = 2; i < 12; i++) drive(seq[i], 1, "busy.rest");
    check("busy.pass", 32'(pass), 32'(1));

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 9) == 0);
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_addr = AW'($urandom_range(0, DEPTH - 1));
      cfg_data = WIDTH'($urandom_range(0, 7));
      if (!m_run) begin
        if ($urandom_range(0, 3) == 0) begin
          cfg_len = LW'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6));
          cfg_mask = ($urandom_range(0, 1) == 0) ? 8'hFF : WIDTH'($urandom);
          tmo_limit = TMO_W'($urandom_range(0, 12));
        end
      end
      if (m_run && $urandom_range(0, 9) < 7)
        io_in = WIDTH'((m_tab[m_idx] & int'(cfg_mask)) | (int'($urandom) & ~int'(cfg_mask)));
      else
        io_in = WIDTH'($urandom_range(0, 7));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
